dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (target) end of the CPU data-memory interface. It accepts load and store requests issued from the pipeline MEM stage and serves them from an internal byte-addressed, 16-bit-word SRAM.
- Access latency is configurable through wait states.
- Every accepted request produces exactly one response pulse, carrying read data or an error flag, plus a busy/stall indication for pipeline hazard logic.

Parameters:
- ADDR_W, 16, byte-address width.
- DEPTH_WORDS, 256, number of 16-bit words stored; the word index is addr[ADDR_W-1:1].
- WAIT_STATES, 2, extra cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (the CPU's reset port name is kept; polarity is low-true).
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  responder can accept this cycle.
- address  in  ADDR_W  byte address.
- write_enable  in  1  store request.
- read_enable  in  1  load request.
- write_data  in  16  store data (byte stores use [7:0]).
- xfer_size  in  4  bytes to transfer: 1 = byte, 2 or 4 = full 16-bit word, any other value is illegal.
- resp_valid  out  1  one-cycle response pulse.
- read_data  out  16  load result, valid with resp_valid.
- resp_err  out  1  error flag, valid with resp_valid.
- busy  out  1  request in flight; the pipeline stalls on this.

Behaviour:
- States: IDLE, WAIT, RESP. The state encoding is 2 bits.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, wait counter = 0.
  - req_ready = 1, resp_valid = 0, resp_err = 0, read_data = 16'h0000, busy = 0.
  - SRAM contents are undefined after reset; the bench must write before reading.
- Acceptance:
  - A request is accepted when req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - On acceptance the block latches address, write/read enables, write_data and xfer_size.
- Transitions:
  - On acceptance, IDLE goes to WAIT with counter = WAIT_STATES.
  - If WAIT_STATES = 0, IDLE goes directly to RESP.
  - In WAIT the counter decrements each cycle; at counter == 1 the next state is RESP.
  - RESP lasts exactly one cycle, then returns to IDLE.
  - Latency from the acceptance edge to resp_valid high is WAIT_STATES+1 cycles. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Memory access:
  - The access is performed on the RESP-entry edge.
  - Word store: mem[idx] <= write_data.
  - Byte store: if address[0] = 0, write mem[idx][7:0]; otherwise write mem[idx][15:8], using write_data[7:0] in both cases.
  - Word load: read_data = mem[idx].
  - Byte load: read_data = {8'h00, selected byte} (zero extension).
  - read_data is held until the next response. It is zeroed on write-only responses and on error responses.
- Errors: resp_err is asserted and memory is NOT modified when any of the following holds:
  - word access with address[0] = 1 (misaligned);
  - idx >= DEPTH_WORDS;
  - illegal xfer_size;
  - write_enable && read_enable both set;
  - neither enable set.
  Error requests still take the full latency.
- Busy: busy = (state != IDLE), which is the combinational complement of req_ready.
- Reset mid-operation: the in-flight request is dropped, no response is issued, and no memory write occurs if reset asserts before the RESP-entry edge.
- req_valid falling without acceptance is legal and has no effect.

Decomposition:
- Shared package dmem_pkg holds:
  - the state typedef (IDLE, WAIT, RESP);
  - the xfer-size constants XFER_BYTE = 4'd1, XFER_HALF = 4'd2, XFER_WORD = 4'd4;
  - the error-cause enum, which is internal only.
- One sub-module, dmem_sram_bank: DEPTH_WORDS x 16 storage with a 2-bit byte-lane write enable and synchronous write / asynchronous read. The FSM, request latch, decode/error checks and counter stay in the top level.

Test Plan:
- Word store then load: store 16'hBEEF to address 16'h0010, then load it. resp_valid rises 3 cycles after each acceptance (WAIT_STATES = 2), read_data = 16'hBEEF, resp_err = 0.
- Byte lanes: word-store 16'h0000 to 16'h0020, byte-store 8'hAB to 16'h0021, then word-load 16'h0020 returns 16'hAB00. A byte load from 16'h0021 returns 16'h00AB.
- Errors:
  - word load at 16'h0003 gives resp_err = 1 and read_data = 0;
  - store to 16'h0400 (idx 512 >= 256) gives resp_err = 1 and memory unchanged;
  - xfer_size = 3 gives resp_err = 1.
- Handshake: hold req_valid high continuously with 4 queued requests. req_ready is high only in IDLE, exactly 4 resp_valid pulses occur at 4-cycle spacing, and busy is high for 3 of every 4 cycles.
- Reset mid-flight: accept a store of 16'h1234 to 16'h0040, assert reset during WAIT, release, then load 16'h0040. No response pulse appears before the load, and the read does not return 16'h1234 (the location is pre-written 16'h5555, which must be read back).
- WAIT_STATES = 0 build: a store followed by a load completes each in 1-cycle latency, with resp_valid one cycle after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// transfer-size encodings and the internal error classification.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam logic [3:0] XFER_BYTE = 4'd1;
    localparam logic [3:0] XFER_HALF = 4'd2;
    localparam logic [3:0] XFER_WORD = 4'd4;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENABLE   = 3'd1,
        ERR_SIZE     = 3'd2,
        ERR_MISALIGN = 3'd3,
        ERR_RANGE    = 3'd4
    } errCauseT;

    // A request is an error if it is not exactly one of load/store, has an
    // unknown size, is a misaligned word access, or falls outside the array.
    function automatic errCauseT classify(input logic       wrEn,
                                          input logic       rdEn,
                                          input logic [3:0] size,
                                          input logic       addrLsb,
                                          input logic       outOfRange);
        if (wrEn == rdEn)
            return ERR_ENABLE;
        if (size != XFER_BYTE && size != XFER_HALF && size != XFER_WORD)
            return ERR_SIZE;
        if (size != XFER_BYTE && addrLsb)
            return ERR_MISALIGN;
        if (outOfRange)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// 16-bit word storage with per-byte-lane write enables; synchronous write,
// asynchronous read, single shared word index.
module dmem_sram_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [1:0]       wrLaneEn,
    input  logic [15:0]      wrData,
    output logic [15:0]      rdData
);

    logic [15:0] mem [DEPTH_WORDS];

    // NOTE: storage arrays are deliberately not reset; clearing them would
    // force flops instead of RAM and the contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wrLaneEn[0])
            mem[idx][7:0] <= wrData[7:0];
        if (wrLaneEn[1])
            mem[idx][15:8] <= wrData[15:8];
    end

    assign rdData = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: accepts one load/store at
// a time, waits WAIT_STATES cycles, then performs the access and pulses resp_valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [15:0]       write_data,
    input  logic [3:0]        xfer_size,
    output logic              resp_valid,
    output logic [15:0]       read_data,
    output logic              resp_err,
    output logic              busy
);

    localparam int                IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    stateT             state;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] reqAddr;
    logic              reqWe;
    logic              reqRe;
    logic [15:0]       reqWdata;
    logic [3:0]        reqSize;

    logic              accept;
    logic              respEntry;
    logic [ADDR_W-1:0] curAddr;
    logic              curWe;
    logic              curRe;
    logic [15:0]       curWdata;
    logic [3:0]        curSize;
    logic [ADDR_W-2:0] wordIdx;
    logic              outOfRange;
    logic              isByte;
    errCauseT          errCause;
    logic [1:0]        laneEn;
    logic [15:0]       laneData;
    logic [15:0]       sramRd;
    logic [15:0]       nextReadData;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge itself,
    // so decode from the live request while idle and from the latch otherwise.
    assign curAddr  = (state == IDLE) ? address      : reqAddr;
    assign curWe    = (state == IDLE) ? write_enable : reqWe;
    assign curRe    = (state == IDLE) ? read_enable  : reqRe;
    assign curWdata = (state == IDLE) ? write_data   : reqWdata;
    assign curSize  = (state == IDLE) ? xfer_size    : reqSize;

    assign respEntry = ((state == WAIT) && (waitCnt == 4'd1)) ||
                       ((WAIT_STATES == 0) && (state == IDLE) && accept);

    assign wordIdx    = curAddr[ADDR_W-1:1];
    assign outOfRange = {1'b0, wordIdx} >= DEPTH_LIM;
    assign isByte     = (curSize == XFER_BYTE);
    assign errCause   = classify(curWe, curRe, curSize, curAddr[0], outOfRange);

    // Byte stores always take write_data[7:0]; replicate it so either lane can use it.
    assign laneData = isByte ? {curWdata[7:0], curWdata[7:0]} : curWdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        laneEn = 2'b00;
        if (respEntry && curWe && (errCause == ERR_NONE))
            laneEn = !isByte ? 2'b11 : (curAddr[0] ? 2'b10 : 2'b01);
    end

    always_comb begin
        nextReadData = 16'h0000;
        if (curRe && (errCause == ERR_NONE))
            nextReadData = !isByte ? sramRd
                                   : {8'h00, (curAddr[0] ? sramRd[15:8] : sramRd[7:0])};
    end

    dmem_sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (clk),
        .idx     (wordIdx[IDX_W-1:0]),
        .wrLaneEn(laneEn),
        .wrData  (laneData),
        .rdData  (sramRd)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            reqAddr    <= '0;
            reqWe      <= 1'b0;
            reqRe      <= 1'b0;
            reqWdata   <= 16'h0000;
            reqSize    <= 4'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            read_data  <= 16'h0000;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqAddr  <= address;
                        reqWe    <= write_enable;
                        reqRe    <= read_enable;
                        reqWdata <= write_data;
                        reqSize  <= xfer_size;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (respEntry) begin
                resp_valid <= 1'b1;
                resp_err   <= (errCause != ERR_NONE);
                read_data  <= nextReadData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance for the main
// scenarios and a WAIT_STATES=0 instance for the single-cycle latency case.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        reqValid, writeEnable, readEnable;
    logic [15:0] address, writeData;
    logic [3:0]  xferSize;
    logic        reqReady, respValid, respErr, busy;
    logic [15:0] readData;

    logic        zReqValid, zWriteEnable, zReadEnable;
    logic [15:0] zAddress, zWriteData;
    logic [3:0]  zXferSize;
    logic        zReqReady, zRespValid, zRespErr, zBusy;
    logic [15:0] zReadData;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady), .address(address),
        .write_enable(writeEnable), .read_enable(readEnable),
        .write_data(writeData), .xfer_size(xferSize),
        .resp_valid(respValid), .read_data(readData), .resp_err(respErr), .busy(busy)
    );

    dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_STATES(0)) dutZero (
        .clk(clk), .reset(reset),
        .req_valid(zReqValid), .req_ready(zReqReady), .address(zAddress),
        .write_enable(zWriteEnable), .read_enable(zReadEnable),
        .write_data(zWriteData), .xfer_size(zXferSize),
        .resp_valid(zRespValid), .read_data(zReadData), .resp_err(zRespErr), .busy(zBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request and wait for its response; lat = cycles from the
    // acceptance cycle to the cycle where resp_valid is seen (-1 if never).
    task automatic doReq(input bit zeroWs, input logic we, input logic re,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [3:0] size,
                         output logic [15:0] rdata, output logic err, output int lat);
        int guard;
        lat   = -1;
        rdata = 16'hxxxx;
        err   = 1'bx;
        @(negedge clk);
        if (zeroWs) begin
            zAddress = addr; zWriteEnable = we; zReadEnable = re;
            zWriteData = wd; zXferSize = size; zReqValid = 1'b1;
        end else begin
            address = addr; writeEnable = we; readEnable = re;
            writeData = wd; xferSize = size; reqValid = 1'b1;
        end
        guard = 0;
        while (!(zeroWs ? zReqReady : reqReady) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready stayed low (addr=%h)", addr);
            reqValid  = 1'b0;
            zReqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        reqValid  = 1'b0;
        zReqValid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (zeroWs ? zRespValid : respValid) begin
                lat   = i;
                rdata = zeroWs ? zReadData : readData;
                err   = zeroWs ? zRespErr : respErr;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (reqReady !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", reqReady); end
        checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", respValid); end
        checks++; if (respErr !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b want 0", respErr); end
        checks++; if (readData !== 16'h0000) begin failures++; $display("FAIL reset_read_data: got %h want 0000", readData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (zReqReady !== 1'b1 || zBusy !== 1'b0) begin failures++; $display("FAIL reset_zero_ready_busy: got %b/%b want 1/0", zReqReady, zBusy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word();
        logic [15:0] rd; logic er; int lat;
        doReq(0, 1, 0, 16'h0010, 16'hBEEF, 4'd4, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL word_store_latency: got %0d want 3", lat); end
        checks++; if (er !== 1'b0 || rd !== 16'h0000) begin failures++; $display("FAIL word_store_resp: err=%b data=%h want 0/0000", er, rd); end
        doReq(0, 0, 1, 16'h0010, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL word_load_latency: got %0d want 3", lat); end
        checks++; if (er !== 1'b0 || rd !== 16'hBEEF) begin failures++; $display("FAIL word_load_data: err=%b data=%h want 0/beef", er, rd); end
        @(negedge clk);
        checks++; if (respValid !== 1'b0 || readData !== 16'hBEEF) begin failures++; $display("FAIL resp_pulse_hold: valid=%b data=%h want 0/beef", respValid, readData); end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] rd; logic er; int lat;
        doReq(0, 1, 0, 16'h0020, 16'h0000, 4'd4, rd, er, lat);
        doReq(0, 1, 0, 16'h0021, 16'h55AB, 4'd1, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL byte_store_hi_err: got %b want 0", er); end
        doReq(0, 0, 1, 16'h0020, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (rd !== 16'hAB00 || er !== 1'b0) begin failures++; $display("FAIL byte_lane_word_load: data=%h err=%b want ab00/0", rd, er); end
        doReq(0, 0, 1, 16'h0021, 16'h0000, 4'd1, rd, er, lat);
        checks++; if (rd !== 16'h00AB || er !== 1'b0) begin failures++; $display("FAIL byte_load_hi: data=%h err=%b want 00ab/0", rd, er); end
        doReq(0, 1, 0, 16'h0020, 16'h66CD, 4'd1, rd, er, lat);
        checks++; if (rd !== 16'h0000 || er !== 1'b0) begin failures++; $display("FAIL byte_store_lo_resp: data=%h err=%b want 0000/0", rd, er); end
        doReq(0, 0, 1, 16'h0020, 16'h0000, 4'd2, rd, er, lat);
        checks++; if (rd !== 16'hABCD || er !== 1'b0) begin failures++; $display("FAIL half_load_both_lanes: data=%h err=%b want abcd/0", rd, er); end
        doReq(0, 0, 1, 16'h0020, 16'h0000, 4'd1, rd, er, lat);
        checks++; if (rd !== 16'h00CD) begin failures++; $display("FAIL byte_load_lo: data=%h want 00cd", rd); end
    endtask

    task automatic test_errors();
        logic [15:0] rd; logic er; int lat;
        doReq(0, 1, 0, 16'h0000, 16'h1111, 4'd4, rd, er, lat);
        doReq(0, 0, 1, 16'h0010, 16'h0000, 4'd4, rd, er, lat);
        doReq(0, 0, 1, 16'h0003, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 16'h0000) begin failures++; $display("FAIL misaligned_load: err=%b data=%h want 1/0000", er, rd); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL error_latency: got %0d want 3", lat); end
        doReq(0, 1, 0, 16'h0400, 16'h7777, 4'd4, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_store_err: got %b want 1", er); end
        doReq(0, 0, 1, 16'h0000, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (rd !== 16'h1111 || er !== 1'b0) begin failures++; $display("FAIL range_store_no_write: data=%h err=%b want 1111/0", rd, er); end
        doReq(0, 0, 1, 16'h0010, 16'h0000, 4'd3, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 16'h0000) begin failures++; $display("FAIL illegal_size: err=%b data=%h want 1/0000", er, rd); end
        doReq(0, 1, 1, 16'h0010, 16'h2222, 4'd4, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL both_enables: err=%b want 1", er); end
        doReq(0, 0, 0, 16'h0010, 16'h3333, 4'd4, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL no_enable: err=%b want 1", er); end
        doReq(0, 0, 1, 16'h0010, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (rd !== 16'hBEEF || er !== 1'b0) begin failures++; $display("FAIL errors_left_memory: data=%h err=%b want beef/0", rd, er); end
    endtask

    task automatic setQueued(input int k);
        logic [15:0] addrs [4] = '{16'h0060, 16'h0062, 16'h0060, 16'h0062};
        logic [15:0] datas [4] = '{16'h0A0A, 16'hB0B0, 16'h0000, 16'h0000};
        address     = addrs[k];
        writeData   = datas[k];
        writeEnable = (k < 2);
        readEnable  = (k >= 2);
        xferSize    = 4'd4;
    endtask

    task automatic test_back_to_back();
        int k = 0, pulses = 0, busyCnt = 0, acc = 0;
        int pulseAt [4];
        logic [15:0] pulseData [4];
        logic a, expBusy;
        @(negedge clk);
        setQueued(0);
        reqValid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(negedge clk);
            expBusy = (n < 16) && (n % 4 != 0);
            checks++;
            if (busy !== expBusy || reqReady !== !expBusy) begin
                failures++;
                $display("FAIL b2b_ready_busy cycle %0d: busy=%b ready=%b want busy=%b", n, busy, reqReady, expBusy);
            end
            if (busy === 1'b1) busyCnt++;
            if (respValid === 1'b1) begin
                if (pulses < 4) begin
                    pulseAt[pulses]   = n;
                    pulseData[pulses] = readData;
                end
                pulses++;
            end
            a = reqReady && reqValid;
            @(posedge clk);
            #1;
            if (a) begin
                k++;
                acc++;
                if (k == 4) reqValid = 1'b0;
                else setQueued(k);
            end
        end
        checks++; if (pulses !== 4 || acc !== 4) begin failures++; $display("FAIL b2b_counts: pulses=%0d accepts=%0d want 4/4", pulses, acc); end
        checks++; if (busyCnt !== 12) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want 12", busyCnt); end
        if (pulses == 4) begin
            checks++;
            if (pulseAt[0] !== 3 || pulseAt[1] !== 7 || pulseAt[2] !== 11 || pulseAt[3] !== 15) begin
                failures++;
                $display("FAIL b2b_spacing: pulses at %0d %0d %0d %0d want 3 7 11 15", pulseAt[0], pulseAt[1], pulseAt[2], pulseAt[3]);
            end
            checks++;
            if (pulseData[2] !== 16'h0A0A || pulseData[3] !== 16'hB0B0) begin
                failures++;
                $display("FAIL b2b_load_data: got %h %h want 0a0a b0b0", pulseData[2], pulseData[3]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] rd; logic er; int lat; int seen = 0;
        doReq(0, 1, 0, 16'h0040, 16'h5555, 4'd4, rd, er, lat);
        @(negedge clk);
        address = 16'h0040; writeData = 16'h1234; writeEnable = 1'b1;
        readEnable = 1'b0; xferSize = 4'd4; reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midflight_in_wait: busy=%b want 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || reqReady !== 1'b1) begin failures++; $display("FAIL midflight_async_reset: busy=%b ready=%b want 0/1", busy, reqReady); end
        repeat (3) begin
            @(negedge clk);
            if (respValid === 1'b1) seen++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (respValid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midflight_no_response: saw %0d pulses want 0", seen); end
        doReq(0, 0, 1, 16'h0040, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (rd !== 16'h5555 || er !== 1'b0) begin failures++; $display("FAIL midflight_no_write: data=%h err=%b want 5555/0", rd, er); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] rd; logic er; int lat;
        doReq(1, 1, 0, 16'h0030, 16'hC3C3, 4'd4, rd, er, lat);
        checks++; if (lat !== 1 || er !== 1'b0) begin failures++; $display("FAIL zero_store: lat=%0d err=%b want 1/0", lat, er); end
        doReq(1, 0, 1, 16'h0030, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (lat !== 1 || rd !== 16'hC3C3) begin failures++; $display("FAIL zero_load: lat=%0d data=%h want 1/c3c3", lat, rd); end
        doReq(1, 0, 1, 16'h0031, 16'h0000, 4'd1, rd, er, lat);
        checks++; if (lat !== 1 || rd !== 16'h00C3 || er !== 1'b0) begin failures++; $display("FAIL zero_byte_load: lat=%0d data=%h err=%b want 1/00c3/0", lat, rd, er); end
        doReq(1, 0, 1, 16'h0031, 16'h0000, 4'd4, rd, er, lat);
        checks++; if (lat !== 1 || er !== 1'b1) begin failures++; $display("FAIL zero_misaligned: lat=%0d err=%b want 1/1", lat, er); end
    endtask

    initial begin
        reqValid = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
        address = 16'h0000; writeData = 16'h0000; xferSize = 4'd4;
        zReqValid = 1'b0; zWriteEnable = 1'b0; zReadEnable = 1'b0;
        zAddress = 16'h0000; zWriteData = 16'h0000; zXferSize = 4'd4;
        reset = 1'b1;
        #1;
        test_reset();
        test_word();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
